// File: rtl/mips_defs.sv
// rtl/mips_defs.sv - shared funct codes and mult/div FSM state encoding
package mips_defs;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  // MULT/MULTU/DIV/DIVU share 0110xx; bit0 = unsigned, bit1 = divide
  function automatic logic is_muldiv(input logic [5:0] f);
    return f[5:2] == 4'b0110;
  endfunction

endpackage

// File: rtl/md_datapath.sv
// rtl/md_datapath.sv - one shift-add multiply or restoring divide step
module md_datapath #(
  parameter int WIDTH = 32
) (
  input  logic             op_div,
  input  logic [WIDTH:0]   acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH:0]   nxt_hi,
  output logic [WIDTH-1:0] nxt_lo
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rsh;
  logic [WIDTH+1:0] diff;

  always_comb begin
    sum  = acc_hi + (acc_lo[0] ? {1'b0, opnd} : '0);
    rsh  = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
    diff = {1'b0, rsh} - {2'b00, opnd};
    if (op_div) begin
      // remainder in acc_hi, dividend shifts out of acc_lo as quotient shifts in
      if (diff[WIDTH+1]) begin
        nxt_hi = rsh;
        nxt_lo = {acc_lo[WIDTH-2:0], 1'b0};
      end else begin
        nxt_hi = diff[WIDTH:0];
        nxt_lo = {acc_lo[WIDTH-2:0], 1'b1};
      end
    end else begin
      nxt_hi = {1'b0, sum[WIDTH:1]};
      nxt_lo = {sum[0], acc_lo[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative mult/div unit with HI/LO registers and busy interlock
module mult_div_unit
  import mips_defs::*;
#(
  parameter int WIDTH = 32,
  parameter int ITER  = WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] INa,
  input  logic [WIDTH-1:0] INb,
  output logic [WIDTH-1:0] OUT,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CW = $clog2(ITER);

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic               op_div, p_neg, q_neg, r_neg;
  logic [WIDTH:0]     acc_hi, nxt_hi;
  logic [WIDTH-1:0]   acc_lo, nxt_lo, opnd;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   abs_a, abs_b, fix_hi, fix_lo;
  logic [2*WIDTH-1:0] prod;

  md_datapath #(.WIDTH(WIDTH)) u_dp (
    .op_div (op_div),
    .acc_hi (acc_hi),
    .acc_lo (acc_lo),
    .opnd   (opnd),
    .nxt_hi (nxt_hi),
    .nxt_lo (nxt_lo)
  );

  always_comb begin
    a_neg  = ~funct[0] & INa[WIDTH-1];
    b_neg  = ~funct[0] & INb[WIDTH-1];
    abs_a  = a_neg ? -INa : INa;
    abs_b  = b_neg ? -INb : INb;
    prod   = {acc_hi[WIDTH-1:0], acc_lo};
    if (p_neg) prod = -prod;
    fix_hi = op_div ? (r_neg ? -acc_hi[WIDTH-1:0] : acc_hi[WIDTH-1:0]) : prod[2*WIDTH-1:WIDTH];
    fix_lo = op_div ? (q_neg ? -acc_lo : acc_lo) : prod[WIDTH-1:0];
    OUT    = (funct == F_MFHI) ? HI : (funct == F_MFLO) ? LO : '0;
    busy   = (state != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      op_div <= 1'b0;
      p_neg  <= 1'b0;
      q_neg  <= 1'b0;
      r_neg  <= 1'b0;
      acc_hi <= '0;
      acc_lo <= '0;
      opnd   <= '0;
      HI     <= '0;
      LO     <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (funct == F_MTHI) HI <= INa;
            else if (funct == F_MTLO) LO <= INa;
            else if (is_muldiv(funct)) begin
              op_div <= funct[1];
              p_neg  <= a_neg ^ b_neg;
              // divide by zero keeps the all-ones quotient unsigned-looking
              q_neg  <= (a_neg ^ b_neg) & (INb != '0);
              r_neg  <= a_neg;
              acc_hi <= '0;
              acc_lo <= abs_a;
              opnd   <= abs_b;
              cnt    <= '0;
              state  <= S_CALC;
            end
          end
        end
        S_CALC: begin
          acc_hi <= nxt_hi;
          acc_lo <= nxt_lo;
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(ITER - 1)) state <= S_FIX;
        end
        S_FIX: begin
          HI    <= fix_hi;
          LO    <= fix_lo;
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - randomized self-checking bench for mult_div_unit
module tb_mult_div_unit;
  import mips_defs::*;

  logic        clk, rst, start;
  logic [5:0]  funct;
  logic [31:0] INa, INb, OUT, HI, LO;
  logic        busy, done;

  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;

  logic [31:0] m_hi, m_lo;
  logic        m_busy, m_done;
  int          m_cnt;
  logic [63:0] m_pend;
  logic [5:0]  ftab [10];

  mult_div_unit dut (
    .clk(clk), .rst(rst), .start(start), .funct(funct), .INa(INa), .INb(INb),
    .OUT(OUT), .busy(busy), .done(done), .HI(HI), .LO(LO)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s act=%h want=%h", name, act, want);
    end
  endtask

  // result as {HI, LO} computed with plain arithmetic
  function automatic logic [63:0] ref_md(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    int ia, ib;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ia = $signed(a);
    ib = $signed(b);
    r = 64'h0;
    case (f)
      F_MULT:  r = 64'(sa * sb);
      F_MULTU: r = {32'h0, a} * {32'h0, b};
      F_DIV: begin
        if (b == 32'h0) r = {a, 32'hFFFFFFFF};
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = {32'h0, 32'h80000000};
        else r = {32'(ia % ib), 32'(ia / ib)};
      end
      F_DIVU: begin
        if (b == 32'h0) r = {a, 32'hFFFFFFFF};
        else r = {a % b, a / b};
      end
      default: r = 64'h0;
    endcase
    return r;
  endfunction

  // reference: each mult/div occupies 33 edges after the launching edge
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_hi = 32'h0; m_lo = 32'h0; m_busy = 1'b0; m_done = 1'b0; m_cnt = 0; m_pend = 64'h0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) begin
          m_hi = m_pend[63:32]; m_lo = m_pend[31:0]; m_busy = 1'b0; m_done = 1'b1;
        end
      end else if (start) begin
        if (funct == F_MTHI) m_hi = INa;
        else if (funct == F_MTLO) m_lo = INa;
        else if (funct[5:2] == 4'b0110) begin
          m_pend = ref_md(funct, INa, INb); m_cnt = 33; m_busy = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 32'(busy), 32'(m_busy));
      check("done", 32'(done), 32'(m_done));
      check("HI", HI, m_hi);
      check("LO", LO, m_lo);
      check("OUT", OUT, (funct == F_MFHI) ? m_hi : (funct == F_MFLO) ? m_lo : 32'h0);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic launch(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; funct = f; INa = a; INb = b;
    step();
    start = 1'b0; funct = 6'h0;
  endtask

  task automatic run_op(input string name, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    int nb, nd;
    nb = 0; nd = 0;
    launch(f, a, b);
    for (int i = 0; i < 40; i++) begin
      if (busy) nb++;
      if (done) nd++;
      step();
    end
    check({name, "_busy_cycles"}, 32'(nb), 32'd33);
    check({name, "_done_pulses"}, 32'(nd), 32'd1);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 6)
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'h1;
      4: return $urandom % 32'd200;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    ftab = '{F_MFHI, F_MTHI, F_MFLO, F_MTLO, F_MULT, F_MULTU, F_DIV, F_DIVU, 6'b100000, 6'b000000};
    rst = 1'b1; start = 1'b0; funct = F_MFHI; INa = 32'h0; INb = 32'h0;
    repeat (3) step();
    check("rst_HI", HI, 32'h0);
    check("rst_LO", LO, 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_OUT", OUT, 32'h0);
    rst = 1'b0;
    funct = 6'h0;
    chk_en = 1'b1;
    step();

    run_op("multu_max", F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    check("multu_max_HI", HI, 32'hFFFFFFFE);
    check("multu_max_LO", LO, 32'h00000001);
    check("model_multu_hi", m_hi, 32'hFFFFFFFE);

    run_op("mult_neg", F_MULT, 32'hFFFFFFFD, 32'd7);
    check("mult_neg_HI", HI, 32'hFFFFFFFF);
    check("mult_neg_LO", LO, 32'hFFFFFFEB);
    funct = F_MFLO;
    #1;
    check("mflo_OUT", OUT, 32'hFFFFFFEB);
    step();

    run_op("div_neg", F_DIV, 32'hFFFFFFF9, 32'd2);
    check("div_neg_LO", LO, 32'hFFFFFFFD);
    check("div_neg_HI", HI, 32'hFFFFFFFF);
    check("model_div_lo", m_lo, 32'hFFFFFFFD);

    run_op("divu", F_DIVU, 32'd100, 32'd7);
    check("divu_LO", LO, 32'd14);
    check("divu_HI", HI, 32'd2);

    run_op("divu_zero", F_DIVU, 32'h12345678, 32'h0);
    check("divu_zero_LO", LO, 32'hFFFFFFFF);
    check("divu_zero_HI", HI, 32'h12345678);

    run_op("div_ovf", F_DIV, 32'h80000000, 32'hFFFFFFFF);
    check("div_ovf_LO", LO, 32'h80000000);
    check("div_ovf_HI", HI, 32'h0);

    launch(F_MULTU, 32'd3, 32'd5);
    repeat (9) step();
    start = 1'b1; funct = F_MTHI; INa = 32'hAAAA;
    step();
    funct = F_DIVU; INa = 32'd100; INb = 32'd7;
    step();
    start = 1'b0; funct = 6'h0;
    repeat (30) step();
    check("ignore_HI", HI, 32'h0);
    check("ignore_LO", LO, 32'd15);
    start = 1'b1; funct = F_MTLO; INa = 32'h55;
    step();
    start = 1'b0; funct = 6'h0;
    check("mtlo_LO", LO, 32'h55);
    check("mtlo_busy", 32'(busy), 32'h0);

    launch(F_DIVU, 32'h12345678, 32'd3);
    repeat (19) step();
    rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 32'h0);
    check("arst_done", 32'(done), 32'h0);
    check("arst_HI", HI, 32'h0);
    check("arst_LO", LO, 32'h0);
    step();
    rst = 1'b0;
    step();
    run_op("post_rst", F_MULTU, 32'd2, 32'd2);
    check("post_rst_LO", LO, 32'd4);
    check("post_rst_HI", HI, 32'h0);

    for (int c = 0; c < 3000; c++) begin
      start = (($urandom % 3) == 0);
      funct = ftab[$urandom % 10];
      INa = pick();
      INb = pick();
      step();
    end
    start = 1'b0; funct = 6'h0;
    repeat (40) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
